// File: rtl/pipe_stage_ctl.sv
// Parametrised MIPS inter-stage pipeline register: DEPTH stages of {valid, ctrl, data}
// with stall (hold), flush (bubble insertion), occupancy and saturating stall counters.
module pipe_stage_ctl #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 12,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Token semantics: a token enters stage 0 on every edge with flush_i=0 and
  // stall_i=0, marked by in_valid. There is no ready: stall_i holds every stage
  // (last one included, so its token is not consumed) and flush_i kills them all.

  logic [DEPTH-1:0]  vld_q;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [2:0]        occ_q;
  logic [CNT_W-1:0]  stall_q;
  logic              advance;

  assign advance = !flush_i && !stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else if (flush_i) begin
      // Data is left in place; only valid and ctrl are cleared so bubbles stay inert.
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_q[k] <= '0;
      end
    end else if (!stall_i) begin
      vld_q[0]  <= in_valid;
      ctrl_q[0] <= in_valid ? in_ctrl : '0;
      data_q[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k]  <= vld_q[k-1];
        ctrl_q[k] <= ctrl_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  // Occupancy tracks the popcount of vld_q without an adder tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (flush_i) begin
      occ_q <= '0;
    end else if (advance) begin
      occ_q <= occ_q + 3'(in_valid) - 3'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!flush_i && stall_i && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign out_valid    = vld_q[DEPTH-1];
  assign out_ctrl     = ctrl_q[DEPTH-1];
  assign out_data     = data_q[DEPTH-1];
  assign occupancy    = occ_q;
  assign stall_cycles = stall_q;

endmodule

// File: doc/pipe_stage_ctl.md
Name: pipe_stage_ctl

Overview:
- Parametrised inter-stage pipeline register for the MIPS pipeline; successor to the fixed ID/EX, EX/MEM and MEM/WB latches.
- Carries a data payload (ALU result, store data, destination) and a control field (Branch/MemRead/MemWrite/RegWrite/... bits) through DEPTH register stages.
- Adds what the fixed latches lack: per-stage valid bit, stall (hold), flush (bubble insertion with control clearing), asynchronous reset, occupancy and stall-cycle counters.

Parameters:
- DATA_W, 69, payload width in bits (default = 32 ALU + 32 store data + 5 destination).
- CTRL_W, 12, control-field width in bits; the control field is zeroed in every bubble.
- DEPTH, 1, number of register stages; legal range 1..4.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- stall_i  input  1  hold every stage this cycle.
- flush_i  input  1  convert every stage to a bubble this cycle.
- in_valid  input  1  an instruction is presented at the input.
- in_ctrl  input  CTRL_W  control bits of the incoming instruction.
- in_data  input  DATA_W  payload of the incoming instruction.
- out_valid  output  1  valid bit of the last stage.
- out_ctrl  output  CTRL_W  control bits of the last stage.
- out_data  output  DATA_W  payload of the last stage.
- occupancy  output  3  number of valid stages, 0..DEPTH.
- stall_cycles  output  CNT_W  saturating count of cycles with stall_i=1 and flush_i=0.

Behaviour:
- Storage: DEPTH stages, each holding valid, ctrl and data. Stage 0 is the input side; stage DEPTH-1 drives the outputs directly (registered outputs, no combinational path from input to output).
- Reset (rst_n=0, asynchronous): all valid=0, ctrl=0, data=0, occupancy=0, stall_cycles=0. All outputs are therefore 0 while in reset and in the first cycle after rst_n rises.
- Per-edge priority: flush_i > stall_i > advance.
- Flush:
  - all valid<=0 and all ctrl<=0; data registers keep their values.
  - occupancy<=0; the input is discarded.
  - stall_cycles does not increment, even when stall_i=1.
- Stall (flush_i=0):
  - all stages hold, including the last stage, whose valid bit is not consumed.
  - occupancy holds; the input is not captured.
  - stall_cycles increments by 1 and saturates at 2^CNT_W-1 (no wrap).
- Advance (flush_i=0, stall_i=0):
  - stage0 <= {in_valid, in_valid ? in_ctrl : 0, in_data}.
  - stage k <= stage k-1 for k = 1..DEPTH-1.
- Invariant: a stage with valid=0 always holds ctrl=0, so an invalid output can never issue RegWrite/MemWrite. The block guarantees this by construction; it does not gate out_ctrl combinationally.
- Latency: a token presented on an advancing edge appears on the outputs after exactly DEPTH advancing edges. Stalled cycles add 1 cycle each. With DEPTH=1 and no stalls the timing is identical to the legacy latches.
- occupancy is a registered counter:
  - on advance: occupancy + in_valid - valid[DEPTH-1] (the token leaving the last stage is dropped).
  - on flush: 0.
  - on stall: unchanged.
  - It always equals the popcount of the valid bits; the bench checks this every cycle.
- in_data is captured even when in_valid=0; that payload is don't-care downstream.
- X-safety: the control inputs stall_i and flush_i are never X after reset; data X-propagation is tolerated.
- Reset asserted mid-stream clears all state immediately, without waiting for a clock edge. There is no pending-operation recovery.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_ctrl=0xFFF, then toggle clk 3 cycles -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cycles=0 throughout.
- Latency (DEPTH=3): drive in_valid=1, in_data=0x0A5, in_ctrl=0x021 for one advancing edge, then in_valid=0 -> outputs appear exactly 3 edges later, held for 1 cycle; occupancy reads 1,1,1 then 0.
- Stall (DEPTH=1): capture in_data=0x1234 with in_valid=1, then assert stall_i for 4 cycles while in_data=0xFFFF -> out_data stays 0x1234 with out_valid=1; stall_cycles=4; on the next advancing edge the new input is taken.
- Flush (DEPTH=2, both stages valid with ctrl=0x0C3): pulse flush_i with stall_i=1 -> next edge: out_valid=0, out_ctrl=0, occupancy=0, out_data unchanged, stall_cycles unchanged.
- Bubble insertion: in_valid=0 with in_ctrl=0xFFF on an advancing edge -> the stage holds ctrl=0, and out_ctrl=0 when that stage reaches the output.
- Saturation (CNT_W=4): hold stall_i=1 for 20 cycles -> stall_cycles stops at 15 and does not wrap. Then drive rst_n=0 asynchronously mid-cycle -> stall_cycles=0 immediately, before the next clk edge.
